// File: rtl/controle_relogio_xadrez_pkg.sv
// Shared definitions for the chess-clock controller: state codes, move-counter
// width, colour encoding and the saturating move-counter helper.
package controle_relogio_xadrez_pkg;

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      VEZ_B   = 3'd1,
      VEZ_P   = 3'd2,
      FIM     = 3'd3,
      PAUSA_B = 3'd4,
      PAUSA_P = 3'd5
   } estado_t;

   localparam int W_JOGADAS = 10;

   localparam logic BRANCO = 1'b0;
   localparam logic PRETO  = 1'b1;

   localparam logic [W_JOGADAS-1:0] JOGADAS_MAX = {W_JOGADAS{1'b1}};

   // Move counter sticks at its maximum instead of wrapping.
   function automatic logic [W_JOGADAS-1:0] incr_sat(input logic [W_JOGADAS-1:0] v);
      logic [W_JOGADAS-1:0] r;
      r = v;
      if (v != JOGADAS_MAX) r = v + 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/controle_relogio_xadrez_relogio_jogador.sv
// One player's remaining-time register: load to M, decrement on tick and
// saturating Fischer credit. The controller decides which action applies.
module relogio_jogador #(
   parameter int M   = 300000,
   parameter int N   = 19,
   parameter int INC = 1000
) (
   input  logic         clock,
   input  logic         zera_n,
   input  logic         carrega,
   input  logic         decrementa,
   input  logic         credita,
   output logic [N-1:0] tempo,
   output logic         zero_prox
);

   localparam logic [N:0]   M_EXT   = (N+1)'(M);
   localparam logic [N:0]   INC_EXT = (N+1)'(INC);
   localparam logic [N-1:0] M_N     = N'(M);

   logic [N-1:0] tempo_q, tempo_d;
   logic [N-1:0] t_dec;
   logic [N:0]   soma;

   always_ff @(posedge clock or negedge zera_n) begin
      if (!zera_n) tempo_q <= M_N;
      else         tempo_q <= tempo_d;
   end

   // The sum is one bit wider so the clamp sees any carry past 2^N.
   always_comb begin
      t_dec = tempo_q;
      if (decrementa && (tempo_q != '0)) t_dec = tempo_q - 1'b1;
      soma    = {1'b0, t_dec} + INC_EXT;
      tempo_d = t_dec;
      if (carrega)      tempo_d = M_N;
      else if (credita) tempo_d = (soma > M_EXT) ? M_N : soma[N-1:0];
   end

   assign zero_prox = (t_dec == '0);
   assign tempo     = tempo_q;

endmodule

// File: rtl/controle_relogio_xadrez.sv
// Two-player chess-clock sequencer: turn FSM, button edge detection, move
// counting and winner tracking; arithmetic lives in relogio_jogador.
module controle_relogio_xadrez
   import controle_relogio_xadrez_pkg::*;
#(
   parameter int M   = 300000,
   parameter int N   = 19,
   parameter int INC = 1000
) (
   input  logic                 clock,
   input  logic                 zera_n,
   input  logic                 tick,
   input  logic                 iniciar,
   input  logic                 pausar,
   input  logic                 jogada_b,
   input  logic                 jogada_p,
   output logic [N-1:0]         tempo_b,
   output logic [N-1:0]         tempo_p,
   output logic                 vez,
   output logic                 pausado,
   output logic                 fim_partida,
   output logic                 vencedor,
   output logic [W_JOGADAS-1:0] num_jogadas,
   output logic [2:0]           db_estado
);

   estado_t estado_q, estado_d;

   logic pausar_ant_q, pausar_ant_d;
   logic jogada_b_ant_q, jogada_b_ant_d;
   logic jogada_p_ant_q, jogada_p_ant_d;
   logic borda_pausa, borda_b, borda_p;

   logic                 vez_q, vez_d;
   logic                 vencedor_q, vencedor_d;
   logic [W_JOGADAS-1:0] jogadas_q, jogadas_d;

   logic carrega, dec_b, dec_p, cred_b, cred_p;
   logic zero_b, zero_p;

   // Previous levels track the buttons in every state, so a button held
   // through a pause or a reset release never yields a second edge.
   always_comb begin
      pausar_ant_d   = pausar;
      jogada_b_ant_d = jogada_b;
      jogada_p_ant_d = jogada_p;
   end

   assign borda_pausa = pausar   & ~pausar_ant_q;
   assign borda_b     = jogada_b & ~jogada_b_ant_q;
   assign borda_p     = jogada_p & ~jogada_p_ant_q;

   always_ff @(posedge clock or negedge zera_n) begin
      if (!zera_n) begin
         estado_q       <= OCIOSO;
         pausar_ant_q   <= 1'b0;
         jogada_b_ant_q <= 1'b0;
         jogada_p_ant_q <= 1'b0;
         vez_q          <= BRANCO;
         vencedor_q     <= BRANCO;
         jogadas_q      <= '0;
      end else begin
         estado_q       <= estado_d;
         pausar_ant_q   <= pausar_ant_d;
         jogada_b_ant_q <= jogada_b_ant_d;
         jogada_p_ant_q <= jogada_p_ant_d;
         vez_q          <= vez_d;
         vencedor_q     <= vencedor_d;
         jogadas_q      <= jogadas_d;
      end
   end

   // Next state: timeout beats a move, a move beats a pause request.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO:  if (iniciar) estado_d = VEZ_B;
         VEZ_B: begin
            if (zero_b)           estado_d = FIM;
            else if (borda_b)     estado_d = VEZ_P;
            else if (borda_pausa) estado_d = PAUSA_B;
         end
         VEZ_P: begin
            if (zero_p)           estado_d = FIM;
            else if (borda_p)     estado_d = VEZ_B;
            else if (borda_pausa) estado_d = PAUSA_P;
         end
         FIM:     if (iniciar)     estado_d = VEZ_B;
         PAUSA_B: if (borda_pausa) estado_d = VEZ_B;
         PAUSA_P: if (borda_pausa) estado_d = VEZ_P;
         default: estado_d = OCIOSO;
      endcase
   end

   always_comb begin
      carrega    = 1'b0;
      dec_b      = 1'b0;
      dec_p      = 1'b0;
      cred_b     = 1'b0;
      cred_p     = 1'b0;
      vez_d      = vez_q;
      vencedor_d = vencedor_q;
      jogadas_d  = jogadas_q;
      pausado     = (estado_q == PAUSA_B) || (estado_q == PAUSA_P);
      fim_partida = (estado_q == FIM);
      case (estado_q)
         OCIOSO: begin
            carrega    = 1'b1;
            vez_d      = BRANCO;
            vencedor_d = BRANCO;
            jogadas_d  = '0;
         end
         VEZ_B: begin
            dec_b = tick;
            if (zero_b) begin
               vencedor_d = PRETO;
            end else if (borda_b) begin
               cred_b    = 1'b1;
               jogadas_d = incr_sat(jogadas_q);
               vez_d     = PRETO;
            end
         end
         VEZ_P: begin
            dec_p = tick;
            if (zero_p) begin
               vencedor_d = BRANCO;
            end else if (borda_p) begin
               cred_p    = 1'b1;
               jogadas_d = incr_sat(jogadas_q);
               vez_d     = BRANCO;
            end
         end
         FIM: begin
            if (iniciar) begin
               carrega    = 1'b1;
               vez_d      = BRANCO;
               vencedor_d = BRANCO;
               jogadas_d  = '0;
            end
         end
         default: ;
      endcase
   end

   relogio_jogador #(.M(M), .N(N), .INC(INC)) u_relogio_b (
      .clock      (clock),
      .zera_n     (zera_n),
      .carrega    (carrega),
      .decrementa (dec_b),
      .credita    (cred_b),
      .tempo      (tempo_b),
      .zero_prox  (zero_b)
   );

   relogio_jogador #(.M(M), .N(N), .INC(INC)) u_relogio_p (
      .clock      (clock),
      .zera_n     (zera_n),
      .carrega    (carrega),
      .decrementa (dec_p),
      .credita    (cred_p),
      .tempo      (tempo_p),
      .zero_prox  (zero_p)
   );

   assign vez         = vez_q;
   assign vencedor    = vencedor_q;
   assign num_jogadas = jogadas_q;
   assign db_estado   = estado_q;

endmodule

// File: tb/tb_controle_relogio_xadrez.sv
// Bench for the chess-clock controller with M=10, INC=3: directed scenarios,
// move-counter saturation and a randomized phase against a game-level model.
module tb_controle_relogio_xadrez;

   localparam int M   = 10;
   localparam int N   = 4;
   localparam int INC = 3;
   localparam int W   = 3 + 4 + 10 + 2*N;

   logic         clock = 1'b0;
   logic         zera_n = 1'b0;
   logic         tick = 1'b0, iniciar = 1'b0, pausar = 1'b0;
   logic         jogada_b = 1'b0, jogada_p = 1'b0;
   logic [N-1:0] tempo_b, tempo_p;
   logic         vez, pausado, fim_partida, vencedor;
   logic [9:0]   num_jogadas;
   logic [2:0]   db_estado;

   controle_relogio_xadrez #(.M(M), .N(N), .INC(INC)) dut (
      .clock       (clock),
      .zera_n      (zera_n),
      .tick        (tick),
      .iniciar     (iniciar),
      .pausar      (pausar),
      .jogada_b    (jogada_b),
      .jogada_p    (jogada_p),
      .tempo_b     (tempo_b),
      .tempo_p     (tempo_p),
      .vez         (vez),
      .pausado     (pausado),
      .fim_partida (fim_partida),
      .vencedor    (vencedor),
      .num_jogadas (num_jogadas),
      .db_estado   (db_estado)
   );

   // clock / reset block
   always #5 clock = ~clock;

   // game-level reference model: mode 0 idle, 1 playing, 2 paused, 3 over
   int m_tb, m_tp, m_moves, m_mode;
   bit m_turn, m_winner;
   bit prev_b, prev_p, prev_pa;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [W-1:0] expected();
      int code;
      case (m_mode)
         0:       code = 0;
         1:       code = m_turn ? 2 : 1;
         2:       code = m_turn ? 5 : 4;
         default: code = 3;
      endcase
      return {3'(code), m_turn, (m_mode == 2), (m_mode == 3), m_winner,
              10'(m_moves), N'(m_tp), N'(m_tb)};
   endfunction

   function automatic logic [W-1:0] actual();
      return {db_estado, vez, pausado, fim_partida, vencedor, num_jogadas, tempo_p, tempo_b};
   endfunction

   task automatic model_reset();
      m_tb = M; m_tp = M; m_moves = 0; m_mode = 0;
      m_turn = 0; m_winner = 0;
      prev_b = 0; prev_p = 0; prev_pa = 0;
   endtask

   task automatic model_step(input bit tk, input bit ini, input bit pau, input bit jb, input bit jp);
      bit eb, ep, epa, mv;
      int t;
      eb = jb && !prev_b;
      ep = jp && !prev_p;
      epa = pau && !prev_pa;
      prev_b = jb; prev_p = jp; prev_pa = pau;
      case (m_mode)
         0: if (ini) m_mode = 1;
         3: if (ini) begin
            m_tb = M; m_tp = M; m_moves = 0; m_winner = 0; m_turn = 0; m_mode = 1;
         end
         1: begin
            t  = m_turn ? m_tp : m_tb;
            if (tk && t > 0) t = t - 1;
            mv = m_turn ? ep : eb;
            if (t == 0) begin
               m_mode = 3;
               m_winner = !m_turn;
            end else if (mv) begin
               t = (t + INC > M) ? M : t + INC;
               if (m_moves < 1023) m_moves = m_moves + 1;
            end else if (epa) begin
               m_mode = 2;
            end
            if (m_turn) m_tp = t; else m_tb = t;
            if (t != 0 && mv) m_turn = !m_turn;
         end
         default: if (epa) m_mode = 1;
      endcase
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got estado=%0d vez=%0d pausado=%0d fim=%0d venc=%0d jog=%0d tp=%0d tb=%0d expected estado=%0d vez=%0d pausado=%0d fim=%0d venc=%0d jog=%0d tp=%0d tb=%0d",
                  name, $time,
                  act[W-1 -: 3], act[W-4], act[W-5], act[W-6], act[W-7], act[2*N +: 10], act[N +: N], act[0 +: N],
                  exp[W-1 -: 3], exp[W-4], exp[W-5], exp[W-6], exp[W-7], exp[2*N +: 10], exp[N +: N], exp[0 +: N]);
      end
   endtask

   // driver: inputs change on the falling edge, expectation queued for the next rise
   task automatic drive(input bit rst_n_v, input bit tk, input bit ini, input bit pau, input bit jb, input bit jp);
      @(negedge clock);
      zera_n = rst_n_v; tick = tk; iniciar = ini; pausar = pau;
      jogada_b = jb; jogada_p = jp;
      if (!rst_n_v) begin
         model_reset();
         #1 check("reset_async", actual(), expected());
      end else begin
         model_step(tk, ini, pau, jb, jp);
      end
      exp_q.push_back(expected());
   endtask

   task automatic go(input bit tk, input bit ini, input bit pau, input bit jb, input bit jp);
      drive(1'b1, tk, ini, pau, jb, jp);
   endtask

   // monitor: the DUT presents a fresh output every cycle
   always @(posedge clock) begin
      logic [W-1:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("saida", actual(), e);
      end
   end

   initial begin
      bit rb, rp, rpa;
      model_reset();

      // reset and start
      repeat (3) drive(1'b0, 0, 0, 0, 0, 0);
      repeat (2) go(0, 0, 0, 0, 0);
      go(0, 1, 0, 0, 0);
      go(0, 0, 0, 0, 0);

      // decrement and increment
      repeat (4) go(1, 0, 0, 0, 0);
      go(0, 0, 0, 1, 0);
      go(0, 0, 0, 0, 0);
      go(1, 0, 0, 0, 1);
      go(0, 0, 0, 0, 0);
      go(1, 0, 0, 1, 0);
      go(0, 0, 0, 0, 0);

      // timeout beats a simultaneous move
      repeat (9) go(1, 0, 0, 0, 0);
      go(1, 0, 0, 0, 1);
      repeat (2) go(0, 0, 0, 0, 0);

      // pause: ticks and moves frozen, resume, pause coinciding with a move
      go(0, 1, 0, 0, 0);
      go(0, 0, 0, 1, 0);
      go(0, 0, 1, 0, 0);
      repeat (5) go(1, 0, 1, 0, 0);
      go(0, 0, 1, 0, 1);
      go(0, 0, 0, 0, 0);
      go(0, 0, 1, 0, 0);
      go(0, 0, 0, 0, 0);
      go(0, 0, 1, 0, 1);
      go(0, 0, 0, 0, 0);

      // held button counts once; opponent's button ignored
      repeat (20) go(0, 0, 0, 1, 0);
      go(0, 0, 0, 0, 0);
      go(0, 0, 0, 0, 1);
      go(0, 0, 0, 0, 0);
      go(1, 0, 0, 0, 1);
      go(0, 0, 0, 0, 0);

      // reset in pause, then iniciar held across FIM, then restart from FIM
      go(0, 0, 1, 0, 0);
      go(0, 0, 0, 0, 0);
      repeat (2) drive(1'b0, 1, 1, 1, 1, 1);
      go(0, 0, 0, 0, 0);
      go(0, 1, 0, 0, 0);
      repeat (14) go(1, 1, 0, 0, 0);
      repeat (12) go(1, 0, 0, 0, 0);
      go(0, 0, 0, 0, 0);
      go(0, 1, 0, 0, 0);
      go(0, 0, 0, 0, 0);

      // move counter saturation
      repeat (520) begin
         go(0, 0, 0, 1, 0);
         go(0, 0, 0, 0, 1);
      end
      go(0, 0, 0, 0, 0);

      // randomized play
      rb = 0; rp = 0; rpa = 0;
      repeat (3000) begin
         if ($urandom_range(0, 2) == 0) rb = ~rb;
         if ($urandom_range(0, 2) == 0) rp = ~rp;
         if ($urandom_range(0, 7) == 0) rpa = ~rpa;
         if ($urandom_range(0, 299) == 0)
            drive(1'b0, 1'($urandom_range(0, 1)), 0, rpa, rb, rp);
         else
            go(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0), rpa, rb, rp);
      end
      go(0, 0, 0, 0, 0);

      repeat (3) @(posedge clock);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
